// File: rtl/alu_seq_if.sv
// Bundle of the ALU sequencer's instruction handshake, register-file and ALU connections.
// The master side is the sequencer; the slave side is decode, RF and ALU.
interface alu_seq_if #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4,
  parameter int IMM_W  = 8
);
  logic              instr_valid;
  logic              instr_ready;
  logic [4:0]        instr_opcode;
  logic [REG_AW-1:0] instr_rsrc;
  logic [REG_AW-1:0] instr_rdest;
  logic [IMM_W-1:0]  instr_imm;
  logic [REG_AW-1:0] rf_raddr;
  logic [DATA_W-1:0] rf_rdata;
  logic              rf_we;
  logic [REG_AW-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [4:0]        alu_opcode;
  logic [DATA_W-1:0] alu_out;
  logic [4:0]        alu_flags;
  logic [4:0]        psr;
  logic              op_done;

  modport master (
    input  instr_valid, instr_opcode, instr_rsrc, instr_rdest, instr_imm,
    input  rf_rdata, alu_out, alu_flags,
    output instr_ready, rf_raddr, rf_we, rf_waddr, rf_wdata,
    output alu_a, alu_b, alu_opcode, psr, op_done
  );

  modport slave (
    output instr_valid, instr_opcode, instr_rsrc, instr_rdest, instr_imm,
    output rf_rdata, alu_out, alu_flags,
    input  instr_ready, rf_raddr, rf_we, rf_waddr, rf_wdata,
    input  alu_a, alu_b, alu_opcode, psr, op_done
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Multicycle sequencer: accept one ALU instruction, read operands, execute, write back result and PSR.
// Define ALU_SEQ_ILLEGAL_TRAP_EN to add the illegal_op trap output for opcodes 11000-11111.
//
// state  | meaning
// IDLE   | ready for an instruction; accept latches opcode, indices, extended immediate
// RD_SRC | read address = source register (register ops only)
// RD_DST | read address = destination register; source data captured for register ops
// LOAD   | destination data captured
// EXEC   | ALU result and flags captured
// WB     | op_done pulse; register write and PSR update unless suppressed
module alu_op_sequencer #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4,
  parameter int IMM_W  = 8
) (
  input  logic clk,
  input  logic rst_n,
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
  output logic illegal_op,
`endif
  alu_seq_if.master bus
);
  localparam logic [4:0] OP_ADDI   = 5'd1;
  localparam logic [4:0] OP_ADDUI  = 5'd3;
  localparam logic [4:0] OP_ADDCI  = 5'd5;
  localparam logic [4:0] OP_ADDCUI = 5'd7;
  localparam logic [4:0] OP_SUBI   = 5'd9;
  localparam logic [4:0] OP_CMP    = 5'd10;
  localparam logic [4:0] OP_CMPI   = 5'd11;
  localparam logic [4:0] OP_CMPUI  = 5'd13;
  localparam logic [4:0] OP_LSHI   = 5'd19;
  localparam logic [4:0] OP_RSHI   = 5'd21;
  localparam logic [4:0] OP_NOP    = 5'd23;

  typedef enum logic [2:0] {
    S_IDLE, S_RD_SRC, S_RD_DST, S_LOAD, S_EXEC, S_WB
  } state_t;

  state_t            state, state_nx;
  logic [DATA_W-1:0] src_q, dst_q, res_q;
  logic [4:0]        flags_q, opcode_q, psr_q;
  logic [REG_AW-1:0] rsrc_q, rdest_q;

  function automatic logic is_imm(input logic [4:0] op);
    case (op)
      OP_ADDI, OP_ADDUI, OP_ADDCI, OP_ADDCUI, OP_SUBI,
      OP_CMPI, OP_CMPUI, OP_LSHI, OP_RSHI: is_imm = 1'b1;
      default:                             is_imm = 1'b0;
    endcase
  endfunction

  // Illegal opcodes share NOP's path: no operand reads, no write, no PSR update.
  function automatic logic is_nop_like(input logic [4:0] op);
    is_nop_like = (op == OP_NOP) || (op[4:3] == 2'b11);
  endfunction

  function automatic logic is_cmp(input logic [4:0] op);
    is_cmp = (op == OP_CMP) || (op == OP_CMPI) || (op == OP_CMPUI);
  endfunction

  function automatic logic [DATA_W-1:0] ext_imm(input logic [4:0] op,
                                                input logic [IMM_W-1:0] imm);
    case (op)
      OP_ADDI, OP_ADDCI, OP_SUBI, OP_CMPI:
        ext_imm = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
      OP_LSHI, OP_RSHI:
        ext_imm = {{(DATA_W-4){1'b0}}, imm[3:0]};
      default:
        ext_imm = {{(DATA_W-IMM_W){1'b0}}, imm};
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      src_q    <= '0;
      dst_q    <= '0;
      res_q    <= '0;
      flags_q  <= '0;
      opcode_q <= '0;
      rsrc_q   <= '0;
      rdest_q  <= '0;
      psr_q    <= '0;
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE: if (bus.instr_valid) begin
          opcode_q <= bus.instr_opcode;
          rsrc_q   <= bus.instr_rsrc;
          rdest_q  <= bus.instr_rdest;
          if (is_imm(bus.instr_opcode)) src_q <= ext_imm(bus.instr_opcode, bus.instr_imm);
        end
        S_RD_DST: if (!is_imm(opcode_q)) src_q <= bus.rf_rdata;
        S_LOAD:   dst_q <= bus.rf_rdata;
        S_EXEC: begin
          res_q   <= bus.alu_out;
          flags_q <= bus.alu_flags;
        end
        S_WB: if (!is_nop_like(opcode_q)) psr_q <= flags_q;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx        = state;
    bus.instr_ready = 1'b0;
    bus.rf_raddr    = '0;
    bus.rf_we       = 1'b0;
    bus.op_done     = 1'b0;
    case (state)
      S_IDLE: begin
        bus.instr_ready = 1'b1;
        if (bus.instr_valid) begin
          if (is_nop_like(bus.instr_opcode))  state_nx = S_WB;
          else if (is_imm(bus.instr_opcode))  state_nx = S_RD_DST;
          else                                state_nx = S_RD_SRC;
        end
      end
      S_RD_SRC: begin
        bus.rf_raddr = rsrc_q;
        state_nx     = S_RD_DST;
      end
      S_RD_DST: begin
        bus.rf_raddr = rdest_q;
        state_nx     = S_LOAD;
      end
      S_LOAD: state_nx = S_EXEC;
      S_EXEC: state_nx = S_WB;
      S_WB: begin
        bus.op_done = 1'b1;
        bus.rf_we   = !is_nop_like(opcode_q) && !is_cmp(opcode_q);
        state_nx    = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign bus.rf_waddr   = rdest_q;
  assign bus.rf_wdata   = res_q;
  assign bus.alu_a      = src_q;
  assign bus.alu_b      = dst_q;
  assign bus.alu_opcode = opcode_q;
  assign bus.psr        = psr_q;

`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
  assign illegal_op = (state == S_WB) && (opcode_q[4:3] == 2'b11);
`endif
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed plus randomized bench for alu_op_sequencer with a behavioural RF/ALU and instruction-level model.
module tb_alu_op_sequencer;
  localparam int K_REG = 0, K_IMM = 1, K_NOP = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic load_rf;
  int   checks = 0, errors = 0, we_cnt = 0;
  logic [15:0] rf [16];
  logic [15:0] model [16];
  logic [15:0] rdata_r;
  logic [4:0]  exp_psr;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
  logic illegal_op;
`endif

  alu_seq_if #(.DATA_W(16), .REG_AW(4), .IMM_W(8)) bus ();

  alu_op_sequencer #(.DATA_W(16), .REG_AW(4), .IMM_W(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
    .illegal_op(illegal_op),
`endif
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Environment ALU: adds for 0-7, subtracts for 8-13, an opcode-salted xor otherwise.
  function automatic logic [20:0] alu_fn(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    logic [15:0] r;
    if (op <= 5'd7)       s = {1'b0, b} + {1'b0, a};
    else if (op <= 5'd13) s = {1'b0, b} - {1'b0, a};
    else                  s = {1'b0, b ^ a ^ {11'd0, op}};
    r = s[15:0];
    return {r, s[16], (b < a), 1'b0, (r == 16'd0), r[15]};
  endfunction

  function automatic int op_kind(input logic [4:0] op);
    if (op >= 5'd23) return K_NOP;
    if (op inside {5'd1, 5'd3, 5'd5, 5'd7, 5'd9, 5'd11, 5'd13, 5'd19, 5'd21}) return K_IMM;
    return K_REG;
  endfunction

  function automatic logic [15:0] ext(input logic [4:0] op, input logic [7:0] imm);
    if (op inside {5'd1, 5'd5, 5'd9, 5'd11}) return 16'($signed(imm));
    if (op inside {5'd19, 5'd21}) return 16'(imm % 16);
    return 16'(imm);
  endfunction

  always_comb {bus.alu_out, bus.alu_flags} = alu_fn(bus.alu_opcode, bus.alu_a, bus.alu_b);
  assign bus.rf_rdata = rdata_r;

  always @(posedge clk) begin
    if (load_rf) for (int i = 0; i < 16; i++) rf[i] <= model[i];
    else if (bus.rf_we) rf[bus.rf_waddr] <= bus.rf_wdata;
    rdata_r <= rf[bus.rf_raddr];
    if (bus.rf_we) we_cnt <= we_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [4:0] op, input logic [3:0] rs, input logic [3:0] rd, input logic [7:0] imm);
    bus.instr_opcode = op;
    bus.instr_rsrc   = rs;
    bus.instr_rdest  = rd;
    bus.instr_imm    = imm;
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after WB.
  task automatic run_op(input logic [4:0] op, input logic [3:0] rs, input logic [3:0] rd,
                        input logic [7:0] imm, input bit hold, input logic [4:0] n_op,
                        input logic [3:0] n_rs, input logic [3:0] n_rd, input logic [7:0] n_imm);
    int kind, lat_e, we0, n;
    bit done;
    logic [15:0] a_e, b_e, r_e;
    logic [4:0]  f_e;
    logic        wr_e;
    logic [3:0]  exp_addr[$];
    logic [3:0]  got_addr[$];
    kind = op_kind(op);
    a_e  = (kind == K_IMM) ? ext(op, imm) : model[rs];
    b_e  = model[rd];
    {r_e, f_e} = alu_fn(op, a_e, b_e);
    wr_e  = (kind != K_NOP) && !(op inside {5'd10, 5'd11, 5'd13});
    lat_e = (kind == K_REG) ? 5 : (kind == K_IMM) ? 4 : 1;
    if (kind == K_REG) exp_addr.push_back(rs);
    if (kind != K_NOP) exp_addr.push_back(rd);
    while (exp_addr.size() < lat_e) exp_addr.push_back(4'd0);

    chk("ready_idle", bus.instr_ready, 1);
    drive(op, rs, rd, imm);
    bus.instr_valid = 1'b1;
    @(posedge clk);
    we0  = we_cnt;
    done = 0;
    n    = 0;
    while (!done && n < 12) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        if (hold) drive(n_op, n_rs, n_rd, n_imm);
        else bus.instr_valid = 1'b0;
      end
      got_addr.push_back(bus.rf_raddr);
      chk("ready_busy", bus.instr_ready, 0);
      if (bus.op_done) begin
        done = 1;
        chk("latency", n, lat_e);
        chk("rf_we_wb", bus.rf_we, wr_e);
        if (kind != K_NOP) begin
          chk("alu_a", bus.alu_a, a_e);
          chk("alu_b", bus.alu_b, b_e);
          chk("alu_opcode", bus.alu_opcode, op);
        end
        if (wr_e) begin
          chk("rf_waddr", bus.rf_waddr, rd);
          chk("rf_wdata", bus.rf_wdata, r_e);
        end
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
        chk("illegal_op", illegal_op, (op >= 5'd24));
`endif
      end
    end
    chk("op_done_seen", done, 1);
    @(negedge clk);
    chk("we_count", we_cnt - we0, wr_e ? 1 : 0);
    if (wr_e) model[rd] = r_e;
    if (kind != K_NOP) exp_psr = f_e;
    chk("psr", bus.psr, exp_psr);
    for (int i = 0; i < 16; i++) chk("rf_contents", rf[i], model[i]);
    chk("raddr_len", got_addr.size(), exp_addr.size());
    for (int i = 0; i < got_addr.size() && i < exp_addr.size(); i++)
      chk("raddr_seq", got_addr[i], exp_addr[i]);
  endtask

  initial begin
    int we0;
    rst_n   = 1'b0;
    load_rf = 1'b1;
    bus.instr_valid = 1'b0;
    drive(5'd0, 4'd0, 4'd0, 8'd0);
    exp_psr = 5'd0;
    for (int i = 0; i < 16; i++) model[i] = 16'($urandom);
    model[1] = 16'h0003; model[2] = 16'h0004;
    model[3] = 16'h1234; model[4] = 16'h1234;
    model[5] = 16'h0010;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n   = 1'b1;
    load_rf = 1'b0;
    @(negedge clk);
    chk("rst_ready", bus.instr_ready, 1);
    chk("rst_psr", bus.psr, 0);
    chk("rst_op_done", bus.op_done, 0);
    chk("rst_rf_we", bus.rf_we, 0);
    chk("rst_alu_a", bus.alu_a, 0);
    chk("rst_alu_b", bus.alu_b, 0);
    chk("rst_raddr", bus.rf_raddr, 0);

    // ADD R1 -> R2
    run_op(5'd0, 4'd1, 4'd2, 8'd0, 0, 5'd0, 4'd0, 4'd0, 8'd0);
    chk("add_r2", rf[2], 16'h0007);
    // SUBI sign-extends 0xFF
    run_op(5'd9, 4'd7, 4'd5, 8'hFF, 0, 5'd0, 4'd0, 4'd0, 8'd0);
    chk("subi_r5", rf[5], 16'h0011);
    // ADDUI zero-extends 0xFF
    run_op(5'd3, 4'd9, 4'd6, 8'hFF, 0, 5'd0, 4'd0, 4'd0, 8'd0);
    // CMP R3,R4 equal values: Z set, no write
    run_op(5'd10, 4'd3, 4'd4, 8'd0, 0, 5'd0, 4'd0, 4'd0, 8'd0);
    chk("cmp_z", bus.psr[1], 1);
    run_op(5'd23, 4'd1, 4'd2, 8'd0, 0, 5'd0, 4'd0, 4'd0, 8'd0);
    run_op(5'd26, 4'd1, 4'd2, 8'h5A, 0, 5'd0, 4'd0, 4'd0, 8'd0);
    run_op(5'd0, 4'd8, 4'd8, 8'd0, 0, 5'd0, 4'd0, 4'd0, 8'd0);

    // Reset in LOAD abandons the ADD
    we0 = we_cnt;
    drive(5'd0, 4'd1, 4'd2, 8'd0);
    bus.instr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk); bus.instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_ready", bus.instr_ready, 1);
    chk("midrst_psr", bus.psr, 0);
    chk("midrst_op_done", bus.op_done, 0);
    rst_n = 1'b1;
    exp_psr = 5'd0;
    @(negedge clk);
    chk("midrst_no_we", we_cnt - we0, 0);
    chk("midrst_r2", rf[2], model[2]);

    // valid held high across a busy op: second instruction only after WB
    run_op(5'd0, 4'd1, 4'd2, 8'd0, 1, 5'd9, 4'd0, 4'd11, 8'h80);
    run_op(5'd9, 4'd0, 4'd11, 8'h80, 0, 5'd0, 4'd0, 4'd0, 8'd0);

    for (int k = 0; k < 40; k++)
      run_op(5'($urandom_range(0, 31)), 4'($urandom), 4'($urandom), 8'($urandom),
             0, 5'd0, 4'd0, 4'd0, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
